weight_ram_ctrl: RTL and testbench
==================================

Name: weight_ram_ctrl

Overview:
Initiator for the 165-entry signed 10-bit weight RAM. On command it fills the RAM with LFSR pseudo-random initial weights. It then serves burst-read requests from the neuron datapath, compensating for the RAM's one-cycle registered read and streaming weights out with valid/last flags. The block sits between the layer sequencer (commands) and the weight RAM (ram_* ports).

Parameters:
NUM_WEIGHTS, 165, number of RAM entries (150 input->hidden + 15 hidden->output)
LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero
INIT_SHIFT, 2, arithmetic right shift applied to raw random weight to bound its magnitude

Ports:
Clock  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
init_start  in  1  one-cycle pulse: randomize all NUM_WEIGHTS entries
rd_start  in  1  one-cycle pulse: begin burst read
rd_base  in  8  first address of burst, sampled on rd_start
rd_len  in  8  number of words in burst, sampled on rd_start
busy  out  1  high while INIT, READ or DRAIN is in progress
init_done  out  1  sticky; set when init completes, cleared on next accepted init_start
err  out  1  one-cycle pulse on a rejected read request
w_valid  out  1  w_data holds a weight this cycle
w_data  out  10  signed weight
w_last  out  1  high with the final w_valid of a burst
ram_addr  out  8  RAM address
ram_we  out  1  1 = write, 0 = read
ram_d  out  10  RAM write data
ram_q  in  10  RAM read data; registered in RAM, valid one cycle after the address is presented with ram_we=0

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; LFSR = LFSR_SEED; counters 0. Reset is asynchronous, and asserting it mid-operation aborts immediately with no partial completion flags.
- LFSR: 16-bit Fibonacci, fb = l[0]^l[2]^l[3]^l[5], next = {fb, l[15:1]}. It advances exactly once per INIT write. It is reseeded only by Rst, so a second init produces a different sequence.
- Random weight: ram_d = $signed(lfsr[9:0]) >>> INIT_SHIFT, taken from the LFSR value before it advances.
- States: IDLE, INIT, READ, DRAIN.
- IDLE:
  - init_start -> INIT, addr=0, init_done cleared.
  - Else rd_start with valid args -> READ.
  - If both pulses arrive in the same cycle, init wins and rd_start is dropped with no err.
  - Command pulses are ignored in any state other than IDLE; err is not raised for them.
- Read validity: rd_len != 0 and rd_base + rd_len <= NUM_WEIGHTS, computed 9-bit with no wrap. A violation gives one err pulse next cycle, the block stays IDLE, and the RAM is not touched.
- INIT: each cycle ram_we=1, ram_addr=addr, ram_d=random weight, addr++.
  - After writing NUM_WEIGHTS-1 -> IDLE; init_done=1 the same cycle ram_we drops.
  - Duration is exactly NUM_WEIGHTS cycles.
- READ: ram_we=0, one address per cycle from rd_base to rd_base+rd_len-1. After the last address issue -> DRAIN.
- DRAIN: 2 cycles for the pipeline to empty, then -> IDLE and busy drops.
- Read latency: address issued in cycle T -> ram_q at T+1 -> registered into w_data with w_valid=1 at T+2.
  - A burst of N words gives N consecutive w_valid cycles with no gaps; no backpressure.
  - w_last accompanies word N.
  - w_data holds its last value when w_valid=0.
- busy=1 from the cycle after an accepted command until the cycle the FSM returns to IDLE.
- ram_addr holds its last value in IDLE; ram_we is 0 whenever not in INIT.

Test Plan:
- Reset then init_start -> ram_we high for exactly 165 consecutive cycles at addresses 0..164; ram_d[0]=+56 (0x0E1>>>2) and ram_d[1]=-100 (0x270>>>2); init_done rises after addr 164; busy falls.
- Preload the RAM model with addr k = k. rd_start base=10 len=5 -> addresses 10..14 issued back-to-back; w_valid on 5 consecutive cycles starting 2 cycles after addr 10; w_data 10,11,12,13,14; w_last only with 14.
- Boundary reads: base=164 len=1 -> single word with w_last; base=160 len=6 -> err pulse, no RAM access, busy stays 0; len=0 -> err.
- init_start and rd_start in the same cycle -> init runs and no read occurs. rd_start while busy -> ignored and no err.
- Second init_start without reset -> ram_d[0] differs from the first run (LFSR continues); init_done drops at start and rises at end.
- Rst low in mid-INIT at addr 80 -> all outputs 0 asynchronously. After release the next init restarts from addr 0 with ram_d[0]=+56.

Source files
------------

// File: rtl/weight_ram_ctrl_if.sv
// rtl/weight_ram_ctrl_if.sv - command, weight stream and RAM port bundle for weight_ram_ctrl
interface weight_ram_ctrl_if;
    logic       init_start;
    logic       rd_start;
    logic [7:0] rd_base;
    logic [7:0] rd_len;
    logic       busy;
    logic       init_done;
    logic       err;
    logic       w_valid;
    logic [9:0] w_data;
    logic       w_last;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [9:0] ram_d;
    logic [9:0] ram_q;

    modport master (
        input  init_start, rd_start, rd_base, rd_len, ram_q,
        output busy, init_done, err, w_valid, w_data, w_last, ram_addr, ram_we, ram_d
    );

    modport slave (
        output init_start, rd_start, rd_base, rd_len, ram_q,
        input  busy, init_done, err, w_valid, w_data, w_last, ram_addr, ram_we, ram_d
    );
endinterface

// File: rtl/weight_ram_ctrl.sv
// rtl/weight_ram_ctrl.sv - weight RAM initiator: LFSR random fill and pipelined burst reads
module weight_ram_ctrl #(
    parameter int          NUM_WEIGHTS = 165,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          INIT_SHIFT  = 2
) (
    input  logic              Clock,
    input  logic              Rst,
    weight_ram_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, INIT, READ, DRAIN} state_t;

    localparam logic [7:0] LAST_ADDR = 8'(NUM_WEIGHTS - 1);
    localparam logic [8:0] NUM_W9    = 9'(NUM_WEIGHTS);

    state_t      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [9:0]  rand_w_d;
    logic [8:0]  rd_end_d;
    logic        rd_ok_d;
    logic [7:0]  end_q;
    logic        drain_q;
    logic        pend_q, pend_last_q;
    logic        busy_q, init_done_q, err_q;
    logic        w_valid_q, w_last_q;
    logic [9:0]  w_data_q;
    logic [7:0]  ram_addr_q;
    logic        ram_we_q;
    logic [9:0]  ram_d_q;

    always_comb begin
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        rand_w_d = $signed(lfsr_q[9:0]) >>> INIT_SHIFT;
        // 9-bit sum so base+len can never wrap past the end of the RAM
        rd_end_d = {1'b0, bus.rd_base} + {1'b0, bus.rd_len};
        rd_ok_d  = (bus.rd_len != 8'd0) && (rd_end_d <= NUM_W9);
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            end_q       <= '0;
            drain_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
            w_data_q    <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_d_q     <= '0;
        end else begin
            err_q <= 1'b0;
            // pend marks the cycle ram_q carries data for an address issued the cycle before
            pend_q      <= (state_q == READ);
            pend_last_q <= (state_q == READ) && (ram_addr_q == end_q);
            w_valid_q   <= pend_q;
            w_last_q    <= pend_last_q;
            if (pend_q) begin
                w_data_q <= bus.ram_q;
            end
            case (state_q)
                IDLE: begin
                    if (bus.init_start) begin
                        state_q     <= INIT;
                        busy_q      <= 1'b1;
                        init_done_q <= 1'b0;
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= '0;
                        ram_d_q     <= rand_w_d;
                        lfsr_q      <= lfsr_d;
                    end else if (bus.rd_start) begin
                        if (rd_ok_d) begin
                            state_q    <= READ;
                            busy_q     <= 1'b1;
                            ram_addr_q <= bus.rd_base;
                            end_q      <= 8'(rd_end_d - 9'd1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    if (ram_addr_q == LAST_ADDR) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        ram_we_q    <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        ram_addr_q <= ram_addr_q + 8'd1;
                        ram_d_q    <= rand_w_d;
                        lfsr_q     <= lfsr_d;
                    end
                end
                READ: begin
                    if (ram_addr_q == end_q) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        ram_addr_q <= ram_addr_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.init_done = init_done_q;
    assign bus.err       = err_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.w_data    = w_data_q;
    assign bus.w_last    = w_last_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_d     = ram_d_q;
endmodule

// File: tb/tb_weight_ram_ctrl.sv
// tb/tb_weight_ram_ctrl.sv - self-checking bench for weight_ram_ctrl
module tb_weight_ram_ctrl;
    localparam int NW = 165;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weight_ram_ctrl_if bus();

    weight_ram_ctrl #(.NUM_WEIGHTS(165), .LFSR_SEED(16'hACE1), .INIT_SHIFT(2)) dut (
        .Clock(clk),
        .Rst  (rst_n),
        .bus  (bus)
    );

    // registered-read RAM owned by the bench
    logic [9:0] ram [0:255];
    logic [9:0] ram_q_r = '0;
    assign bus.ram_q = ram_q_r;
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_d;
        else            ram_q_r <= ram[bus.ram_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // reference model: LFSR sequence and expected RAM contents
    logic [15:0] lfsr_m;
    logic [9:0]  mem_ref [0:255];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic int weight_of(input logic [15:0] l);
        int v;
        v = int'(l[9:0]);
        if (v >= 512) v = v - 1024;
        return (v >= 0) ? v / 4 : -((-v + 3) / 4);
    endfunction

    function automatic logic [63:0] outs();
        return {30'd0, bus.busy, bus.init_done, bus.err, bus.w_valid, bus.w_last,
                bus.ram_we, bus.w_data, bus.ram_addr, bus.ram_d};
    endfunction

    // observation monitor
    logic [7:0] wr_addr [$];
    logic [9:0] wr_data [$];
    int         wr_cyc  [$];
    logic [9:0] rd_data [$];
    logic       rd_last [$];
    int         rd_cyc  [$];
    int         err_cnt = 0;
    bit         busy_seen = 0;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_we) begin
                wr_addr.push_back(bus.ram_addr);
                wr_data.push_back(bus.ram_d);
                wr_cyc.push_back(cyc);
            end
            if (bus.w_valid) begin
                rd_data.push_back(bus.w_data);
                rd_last.push_back(bus.w_last);
                rd_cyc.push_back(cyc);
            end
            if (bus.err)  err_cnt++;
            if (bus.busy) busy_seen = 1'b1;
        end
    end

    task automatic clear_mon();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        rd_data.delete(); rd_last.delete(); rd_cyc.delete();
        err_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    // mode 0: plain, 1: rd_start in the same cycle, 2: rd_start while busy
    task automatic do_init(input int mode);
        logic [9:0] exp_d [NW];
        int n, bad_a, bad_d;
        n = 0; bad_a = 0; bad_d = 0;
        for (int k = 0; k < NW; k++) begin
            exp_d[k] = 10'(weight_of(lfsr_m));
            lfsr_m   = lfsr_next(lfsr_m);
        end
        clear_mon();
        @(negedge clk);
        bus.init_start = 1'b1;
        if (mode == 1) begin
            bus.rd_base = 8'd10; bus.rd_len = 8'd5; bus.rd_start = 1'b1;
        end
        @(negedge clk);
        bus.init_start = 1'b0;
        bus.rd_start   = 1'b0;
        chk($sformatf("init%0d_done_cleared", mode), bus.init_done, 0);
        chk($sformatf("init%0d_busy_start", mode), bus.busy, 1);
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
            if (mode == 2 && n == 50) begin
                bus.rd_base = 8'd0; bus.rd_len = 8'd3; bus.rd_start = 1'b1;
            end
            if (mode == 2 && n == 51) bus.rd_start = 1'b0;
        end
        chk($sformatf("init%0d_timeout", mode), n < 400, 1);
        chk($sformatf("init%0d_done_set", mode), bus.init_done, 1);
        chk($sformatf("init%0d_write_count", mode), wr_addr.size(), NW);
        for (int k = 0; k < wr_addr.size() && k < NW; k++) begin
            if (wr_addr[k] !== 8'(k))  bad_a++;
            if (wr_data[k] !== exp_d[k]) bad_d++;
        end
        chk($sformatf("init%0d_addr_seq_errors", mode), bad_a, 0);
        chk($sformatf("init%0d_data_errors", mode), bad_d, 0);
        if (wr_cyc.size() > 0)
            chk($sformatf("init%0d_write_span", mode), wr_cyc[wr_cyc.size()-1] - wr_cyc[0] + 1, NW);
        repeat (6) @(negedge clk);
        chk($sformatf("init%0d_no_read", mode), rd_data.size(), 0);
        chk($sformatf("init%0d_no_err", mode), err_cnt, 0);
        chk($sformatf("init%0d_we_low_after", mode), bus.ram_we, 0);
        for (int k = 0; k < NW; k++) mem_ref[k] = exp_d[k];
    endtask

    task automatic do_read(input logic [7:0] base, input logic [7:0] len, input bit exp_err);
        logic [7:0] addr_before;
        int n, bad_d, bad_l;
        n = 0; bad_d = 0; bad_l = 0;
        addr_before = bus.ram_addr;
        clear_mon();
        @(negedge clk);
        bus.rd_base = base; bus.rd_len = len; bus.rd_start = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk($sformatf("rd_timeout b%0d l%0d", base, len), n < 400, 1);
        if (exp_err) begin
            chk($sformatf("rd_err_pulse b%0d l%0d", base, len), err_cnt, 1);
            chk($sformatf("rd_err_no_busy b%0d l%0d", base, len), busy_seen, 0);
            chk($sformatf("rd_err_no_data b%0d l%0d", base, len), rd_data.size(), 0);
            chk($sformatf("rd_err_addr_held b%0d l%0d", base, len), bus.ram_addr, addr_before);
        end else begin
            chk($sformatf("rd_no_err b%0d l%0d", base, len), err_cnt, 0);
            chk($sformatf("rd_count b%0d l%0d", base, len), rd_data.size(), len);
            for (int i = 0; i < rd_data.size() && i < int'(len); i++) begin
                if (rd_data[i] !== mem_ref[int'(base) + i]) bad_d++;
                if (rd_last[i] !== (i == int'(len) - 1))    bad_l++;
            end
            chk($sformatf("rd_data_errors b%0d l%0d", base, len), bad_d, 0);
            chk($sformatf("rd_last_errors b%0d l%0d", base, len), bad_l, 0);
            if (rd_cyc.size() > 0)
                chk($sformatf("rd_span b%0d l%0d", base, len),
                    rd_cyc[rd_cyc.size()-1] - rd_cyc[0] + 1, len);
        end
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] len;
        bit         err;
    } rd_vec_t;

    rd_vec_t vecs [8];

    logic [7:0] a_s [9];
    logic       v_s [9];
    logic [9:0] d_s [9];
    logic       l_s [9];
    logic       b_s [9];

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] rb, rl;
        vecs[0] = '{8'd164, 8'd1,   1'b0};
        vecs[1] = '{8'd160, 8'd6,   1'b1};
        vecs[2] = '{8'd0,   8'd0,   1'b1};
        vecs[3] = '{8'd150, 8'd15,  1'b0};
        vecs[4] = '{8'd0,   8'd165, 1'b0};
        vecs[5] = '{8'd200, 8'd1,   1'b1};
        vecs[6] = '{8'd255, 8'd255, 1'b1};
        vecs[7] = '{8'd163, 8'd2,   1'b0};

        for (int k = 0; k < 256; k++) begin
            ram[k]     = '0;
            mem_ref[k] = '0;
        end
        lfsr_m         = 16'hACE1;
        bus.init_start = 1'b0;
        bus.rd_start   = 1'b0;
        bus.rd_base    = '0;
        bus.rd_len     = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs_during", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs_after", outs(), 0);

        do_init(0);
        if (wr_data.size() >= 2) begin
            chk("init1_d0_plus56", wr_data[0], 10'h038);
            chk("init1_d1_minus100", wr_data[1], 10'h39C);
        end

        // preload addr k = k for the hand-written burst
        for (int k = 0; k < 256; k++) begin
            ram[k]     = 10'(k);
            mem_ref[k] = 10'(k);
        end
        @(negedge clk);
        bus.rd_base = 8'd10; bus.rd_len = 8'd5; bus.rd_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.rd_start = 1'b0;
            a_s[c] = bus.ram_addr;
            v_s[c] = bus.w_valid;
            d_s[c] = bus.w_data;
            l_s[c] = bus.w_last;
            b_s[c] = bus.busy;
        end
        for (int c = 1; c <= 5; c++)
            chk($sformatf("burst_addr_c%0d", c), a_s[c], 9 + c);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("burst_valid_c%0d", c), v_s[c], (c >= 3 && c <= 7));
            chk($sformatf("burst_last_c%0d", c), l_s[c], (c == 7));
            if (c >= 3 && c <= 7) chk($sformatf("burst_data_c%0d", c), d_s[c], c + 7);
        end
        chk("burst_data_hold", d_s[8], 14);
        chk("burst_busy_drain", b_s[7], 1);
        chk("burst_busy_drop", b_s[8], 0);

        for (int i = 0; i < 8; i++) do_read(vecs[i].base, vecs[i].len, vecs[i].err);

        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom_range(0, 175));
            rl = 8'($urandom_range(0, 16));
            do_read(rb, rl, (rl == 0) || (int'(rb) + int'(rl) > NW));
        end

        do_init(1);
        if (wr_data.size() >= 1) chk("init2_d0_differs", wr_data[0] != 10'h038, 1);
        do_init(2);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 164));
            rl = 8'($urandom_range(1, 12));
            do_read(rb, rl, (int'(rb) + int'(rl) > NW));
        end

        // abort an init mid-way with an asynchronous reset
        clear_mon();
        @(negedge clk);
        bus.init_start = 1'b1;
        @(negedge clk);
        bus.init_start = 1'b0;
        n = 0;
        while (!(bus.ram_we && bus.ram_addr == 8'd80) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("midinit_reach_80", n < 300, 1);
        #2 rst_n = 1'b0;
        #1 chk("midinit_async_reset_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        chk("midinit_held_reset_outputs", outs(), 0);
        rst_n  = 1'b1;
        lfsr_m = 16'hACE1;
        @(negedge clk);
        chk("midinit_no_done_after", bus.init_done, 0);
        do_init(0);
        if (wr_data.size() >= 1) chk("reinit_d0_plus56", wr_data[0], 10'h038);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
